// File: rtl/alu_seq.sv
// alu_seq: multi-cycle integer ALU between decode and writeback with valid/ready on both sides.
// Iterative multiply/divide (mul, mulhu, divu, remu) is built only when ALU_MULDIV_EN is defined.
module alu_seq #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [5:0]      alu_op,
    input  logic [XLEN-1:0] oprend1,
    input  logic [XLEN-1:0] oprend2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal,
    output logic            busy
);

    // state | meaning
    // IDLE  | ready for a request; single-cycle ops register their result on accept
    // CALC  | one radix-2 multiply/divide step per cycle, XLEN steps in total
    // DONE  | result held valid until the consumer takes it
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [5:0] OP_ADD   = 6'b000001;
    localparam logic [5:0] OP_SUB   = 6'b000010;
    localparam logic [5:0] OP_SLL   = 6'b000011;
    localparam logic [5:0] OP_SRL   = 6'b001011;
    localparam logic [5:0] OP_AND   = 6'b000110;
    localparam logic [5:0] OP_OR    = 6'b000111;
    localparam logic [5:0] OP_XOR   = 6'b001000;
    localparam logic [5:0] OP_SRA   = 6'b001110;
    localparam logic [5:0] OP_SLT   = 6'b001111;
    localparam logic [5:0] OP_SLTU  = 6'b010000;
    localparam logic [5:0] OP_MUL   = 6'b010001;
    localparam logic [5:0] OP_MULHU = 6'b010010;
    localparam logic [5:0] OP_DIVU  = 6'b010011;
    localparam logic [5:0] OP_REMU  = 6'b010100;

    state_t state;

    function automatic logic is_single(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_SLL, OP_SRL, OP_AND, OP_OR, OP_XOR,
            OP_SRA, OP_SLT, OP_SLTU: return 1'b1;
            default:                 return 1'b0;
        endcase
    endfunction

    // Unsupported codes fall through to zero, which is also the required illegal result.
    function automatic logic [XLEN-1:0] alu_fn(input logic [5:0]      op,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
        logic [SHW-1:0] sh;
        sh = b[SHW-1:0];
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_SLL:  return a << sh;
            OP_SRL:  return a >> sh;
            OP_SRA:  return $signed(a) >>> sh;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SLT:  return {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU: return {{(XLEN-1){1'b0}}, a < b};
            default: return '0;
        endcase
    endfunction

`ifdef ALU_MULDIV_EN
    logic [5:0]        op_r;
    logic [XLEN-1:0]   opb_r;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] acc_next;
    logic [SHW-1:0]    cnt;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_trial;
    logic [XLEN:0]     div_diff;

    function automatic logic is_muldiv(input logic [5:0] op);
        return (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

    // acc holds {partial product, multiplier} for mul and {remainder, dividend/quotient} for div,
    // so after XLEN steps the high half is mulhu/remu and the low half is mul/divu.
    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb_r} : '0);
        div_trial = acc[2*XLEN-1:XLEN-1];
        div_diff  = div_trial - {1'b0, opb_r};
        if (op_r == OP_MUL || op_r == OP_MULHU)
            acc_next = {mul_sum, acc[XLEN-1:1]};
        else if (div_diff[XLEN])
            acc_next = {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        else
            acc_next = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            result  <= '0;
            illegal <= 1'b0;
`ifdef ALU_MULDIV_EN
            op_r    <= '0;
            opb_r   <= '0;
            acc     <= '0;
            cnt     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
`ifdef ALU_MULDIV_EN
                        if (is_muldiv(alu_op)) begin
                            state   <= CALC;
                            op_r    <= alu_op;
                            opb_r   <= oprend2;
                            acc     <= {{XLEN{1'b0}}, oprend1};
                            cnt     <= '0;
                            illegal <= 1'b0;
                        end else
`endif
                        begin
                            state   <= DONE;
                            result  <= alu_fn(alu_op, oprend1, oprend2);
                            illegal <= ~is_single(alu_op);
                        end
                    end
                end
                CALC: begin
`ifdef ALU_MULDIV_EN
                    acc <= acc_next;
                    cnt <= cnt + SHW'(1);
                    if (cnt == SHW'(XLEN-1)) begin
                        state  <= DONE;
                        result <= (op_r == OP_MULHU || op_r == OP_REMU) ?
                                  acc_next[2*XLEN-1:XLEN] : acc_next[XLEN-1:0];
                    end
`else
                    state <= IDLE;
`endif
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);
    assign zero      = (result == '0);

endmodule
